// File: rtl/elem_pkg.sv
// Shared elementwise datapath types and sizes (also used by elem_add).
// ELEM_WB_FLUSH_EN enables partial-row flush support in elem_row_writeback.
package elem_pkg;

    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned INPUT_NUM = 12;
    localparam int unsigned ROW_NUM   = 24;
    localparam int unsigned ADDR_SIZE = 20;
    localparam int unsigned BLK_NUM   = ROW_NUM / INPUT_NUM;
    localparam int unsigned CNT_W     = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;

    localparam logic [ADDR_SIZE-1:0] ADDR_BASE = '0;
    localparam logic [ADDR_SIZE-1:0] ADDR_OFFU = ADDR_SIZE'(1);

    typedef logic [DATA_SIZE-1:0] elem_t;
    typedef elem_t [INPUT_NUM-1:0] blk_t;
    typedef elem_t [ROW_NUM-1:0]   row_t;

    // Element-valid mask covering the first nblk blocks of a row.
    function automatic logic [ROW_NUM-1:0] blk_mask(input logic [CNT_W:0] nblk);
        logic [ROW_NUM-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < ROW_NUM; i++) begin
            m[i] = (i < 32'(nblk) * INPUT_NUM);
        end
        return m;
    endfunction

endpackage

// File: rtl/elem_row_buf.sv
// One row buffer: block slots, full flag, and (with ELEM_WB_FLUSH_EN) an element-valid mask.
module elem_row_buf
    import elem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] slot,
    input  blk_t             blk,
    input  logic             set_full,
    input  logic             drain,
`ifdef ELEM_WB_FLUSH_EN
    input  logic [ROW_NUM-1:0] mask_in,
    output logic [ROW_NUM-1:0] mask,
`endif
    output logic             full,
    output row_t             row
);

    blk_t [BLK_NUM-1:0] slots;

    // set_full wins over drain: a buffer freed this cycle may refill and close in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
            full  <= 1'b0;
`ifdef ELEM_WB_FLUSH_EN
            mask  <= '0;
`endif
        end else begin
            if (load) begin
                slots[slot] <= blk;
            end
            if (clr) begin
                full <= 1'b0;
            end else if (set_full) begin
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
`ifdef ELEM_WB_FLUSH_EN
            if (clr) begin
                mask <= '0;
            end else if (set_full) begin
                mask <= mask_in;
            end
`endif
        end
    end

    assign row = row_t'(slots);

endmodule

// File: rtl/elem_row_writeback.sv
// Collects result blocks into rows and writes them to SRAM through ping-pong buffers.
// ELEM_WB_FLUSH_EN adds flush / wr_mask for writing partial rows.
module elem_row_writeback
    import elem_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [INPUT_NUM*DATA_SIZE-1:0] data_in,
    input  logic                           addr_reset,
`ifdef ELEM_WB_FLUSH_EN
    input  logic                           flush,
    output logic [ROW_NUM-1:0]             wr_mask,
`endif
    output logic                           wr_en,
    input  logic                           wr_ready,
    output logic [ADDR_SIZE-1:0]           wr_addr,
    output logic [ROW_NUM*DATA_SIZE-1:0]   wr_data,
    output logic                           overflow
);

    logic [CNT_W-1:0]     blk_cnt, blk_cnt_nxt;
    logic                 fill_sel, fill_sel_nxt;
    logic                 rd_sel, rd_sel_nxt;
    logic [ADDR_SIZE-1:0] wr_addr_nxt;
    logic                 wr_en_nxt, overflow_nxt;
    logic [1:0]           full, full_nxt, load, set_full, drain;
    logic                 accept, fill_full, store, drop, last, close;
    row_t                 rows [2];
`ifdef ELEM_WB_FLUSH_EN
    logic [ROW_NUM-1:0]   masks [2];
    logic [ROW_NUM-1:0]   mask_in;
    logic [CNT_W:0]       cnt_after;
    logic                 flush_do;
`endif

    // Next-state: drain first, then fill against the post-drain buffer state.
    always_comb begin
        accept    = wr_en & wr_ready;
        fill_full = full[fill_sel] & ~(accept & (rd_sel == fill_sel));
        store     = in_valid & ~fill_full & ~addr_reset;
        drop      = in_valid & fill_full & ~addr_reset;
        last      = store & (blk_cnt == CNT_W'(BLK_NUM - 1));
        close     = last;
`ifdef ELEM_WB_FLUSH_EN
        cnt_after = store ? ((CNT_W+1)'(blk_cnt) + (CNT_W+1)'(1)) : (CNT_W+1)'(blk_cnt);
        flush_do  = flush & ~addr_reset & ~last & (cnt_after != '0);
        close     = last | flush_do;
        mask_in   = last ? '1 : blk_mask(cnt_after);
`endif
        load     = '0;
        set_full = '0;
        drain    = '0;
        load[fill_sel]     = store;
        set_full[fill_sel] = close;
        drain[rd_sel]      = accept;

        full_nxt     = set_full | (full & ~drain);
        blk_cnt_nxt  = close ? '0 : (store ? blk_cnt + CNT_W'(1) : blk_cnt);
        fill_sel_nxt = fill_sel ^ close;
        rd_sel_nxt   = rd_sel ^ accept;
        wr_addr_nxt  = accept ? wr_addr + ADDR_OFFU : wr_addr;
        overflow_nxt = overflow | drop;

        if (addr_reset) begin
            full_nxt     = '0;
            blk_cnt_nxt  = '0;
            fill_sel_nxt = 1'b0;
            rd_sel_nxt   = 1'b0;
            wr_addr_nxt  = ADDR_BASE;
            overflow_nxt = 1'b0;
        end
        wr_en_nxt = full_nxt[rd_sel_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt  <= '0;
            fill_sel <= 1'b0;
            rd_sel   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= ADDR_BASE;
            overflow <= 1'b0;
        end else begin
            blk_cnt  <= blk_cnt_nxt;
            fill_sel <= fill_sel_nxt;
            rd_sel   <= rd_sel_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            overflow <= overflow_nxt;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        elem_row_buf u_buf (
            .clk      (clk),
            .rst      (rst),
            .clr      (addr_reset),
            .load     (load[g]),
            .slot     (blk_cnt),
            .blk      (blk_t'(data_in)),
            .set_full (set_full[g]),
            .drain    (drain[g]),
`ifdef ELEM_WB_FLUSH_EN
            .mask_in  (mask_in),
            .mask     (masks[g]),
`endif
            .full     (full[g]),
            .row      (rows[g])
        );
    end

    // Pending row is held stable in its buffer until accepted.
    assign wr_data = rd_sel ? rows[1] : rows[0];
`ifdef ELEM_WB_FLUSH_EN
    assign wr_mask = rd_sel ? masks[1] : masks[0];
`endif

endmodule
